// File: rtl/udp_pkg.sv
// udp_pkg: shared types and constants for the UDP packer.
// Contents: FSM state enum, UDP header payload struct, header sizes,
// payload limits and the header byte selector.
// Optional feature macro: UDP_MIN_PAD_EN (adds the PAD state).
package udp_pkg;

  localparam int unsigned UDP_HDR_NIBBLES = 16;
  localparam int unsigned UDP_HDR_BYTES   = 8;
  localparam int unsigned UDP_MIN_PAYLOAD = 18;
  localparam int unsigned UDP_MAX_PAYLOAD = 1472;
  localparam int unsigned LEN_W           = 12;
  localparam int unsigned PORT_W          = 16;
  localparam int unsigned NIB_CNT_W       = 13;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    HDR  = 3'd1,
    PAY  = 3'd2,
`ifdef UDP_MIN_PAD_EN
    PAD  = 3'd3,
`endif
    FIN  = 3'd4
  } state_e;

  typedef struct packed {
    logic [PORT_W-1:0] src_port;
    logic [PORT_W-1:0] dst_port;
    logic [15:0]       length;
    logic [15:0]       checksum;
  } udp_hdr_t;

  typedef logic [$clog2(UDP_HDR_BYTES)-1:0] hdr_idx_t;

  // Header byte at wire position idx; each field goes out MSB byte first.
  function automatic logic [7:0] hdr_byte(input hdr_idx_t idx, input udp_hdr_t h);
    hdr_byte = 8'h00;
    case (idx)
      3'd0:    hdr_byte = h.src_port[15:8];
      3'd1:    hdr_byte = h.src_port[7:0];
      3'd2:    hdr_byte = h.dst_port[15:8];
      3'd3:    hdr_byte = h.dst_port[7:0];
      3'd4:    hdr_byte = h.length[15:8];
      3'd5:    hdr_byte = h.length[7:0];
      3'd6:    hdr_byte = h.checksum[15:8];
      default: hdr_byte = h.checksum[7:0];
    endcase
  endfunction

endpackage

// File: rtl/udp_packer_ser.sv
// udp_nibble_ser: splits the current byte into nibbles, low nibble first.
// Ports: mii_tx_clk, rst_n (async, active-low); i_clr clears the phase,
// i_adv steps to the next nibble, i_byte is the byte being sent,
// o_nib_c is the nibble for the current phase (combinational),
// o_phase_hi is 1 while the high nibble is due.
module udp_nibble_ser (
  input  logic       mii_tx_clk,
  input  logic       rst_n,
  input  logic       i_clr,
  input  logic       i_adv,
  input  logic [7:0] i_byte,
  output logic [3:0] o_nib_c,
  output logic       o_phase_hi
);

  logic r_phase_hi;

  // Phase flips on every accepted nibble, so a byte completes every second step.
  always_ff @(posedge mii_tx_clk or negedge rst_n) begin
    if (!rst_n)     r_phase_hi <= 1'b0;
    else if (i_clr) r_phase_hi <= 1'b0;
    else if (i_adv) r_phase_hi <= ~r_phase_hi;
  end

  assign o_nib_c    = r_phase_hi ? i_byte[7:4] : i_byte[3:0];
  assign o_phase_hi = r_phase_hi;

endmodule

// File: rtl/udp_packer.sv
// udp_packer: builds a UDP datagram (8-byte header + payload) as a nibble
// stream for the IP stage, pulling payload bytes from a show-ahead FIFO.
// Ports: mii_tx_clk, rst_n (async, active-low); start/payload_len/src_port/
// dst_port request a datagram; pl_empty/pl_data/pl_rd = payload FIFO (pl_rd
// is combinational); tx_go_o/ip_data_len/nib_rq/nib_da = IP stage handshake;
// busy/done/len_err/underrun = status.
// Optional feature macro: UDP_MIN_PAD_EN pads short payloads to 18 bytes.
module udp_packer
  import udp_pkg::*;
(
  input  logic                 mii_tx_clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [LEN_W-1:0]     payload_len,
  input  logic [PORT_W-1:0]    src_port,
  input  logic [PORT_W-1:0]    dst_port,
  input  logic                 pl_empty,
  input  logic [7:0]           pl_data,
  output logic                 pl_rd,
  output logic                 tx_go_o,
  output logic [LEN_W-1:0]     ip_data_len,
  input  logic                 nib_rq,
  output logic [3:0]           nib_da,
  output logic                 busy,
  output logic                 done,
  output logic                 len_err,
  output logic                 underrun
);

  state_e                r_state;
  state_e                w_next;
  logic [PORT_W-1:0]     r_src;
  logic [PORT_W-1:0]     r_dst;
  logic [LEN_W-1:0]      r_len;
  logic [3:0]            r_hdr_nib;
  logic [NIB_CNT_W-1:0]  r_nib_cnt;
  udp_hdr_t              w_hdr;
  logic                  w_accept;
  logic                  w_reject;
  logic                  w_stream;
  logic                  w_adv;
  logic                  w_pl_rd;
  logic [7:0]            w_byte;
  logic [3:0]            w_nib;
  logic                  w_phase_hi;
  logic                  w_pad_need;
  logic [NIB_CNT_W-1:0]  w_pad_nibs;
  logic [LEN_W-1:0]      w_ip_len;

  assign w_hdr = '{src_port: r_src, dst_port: r_dst,
                   length: 16'(r_len) + 16'd8, checksum: 16'h0000};

`ifdef UDP_MIN_PAD_EN
  // Pad length is only meaningful while r_len is below the minimum.
  assign w_pad_need = (r_len < LEN_W'(UDP_MIN_PAYLOAD));
  assign w_pad_nibs = {1'b0, LEN_W'(UDP_MIN_PAYLOAD) - r_len} << 1;
  assign w_ip_len   = (payload_len < LEN_W'(UDP_MIN_PAYLOAD))
                      ? LEN_W'(UDP_MIN_PAYLOAD + UDP_HDR_BYTES)
                      : LEN_W'(payload_len + LEN_W'(UDP_HDR_BYTES));
`else
  assign w_pad_need = 1'b0;
  assign w_pad_nibs = '0;
  assign w_ip_len   = LEN_W'(payload_len + LEN_W'(UDP_HDR_BYTES));
`endif

  // State register.
  always_ff @(posedge mii_tx_clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_next;
  end

  // Next-state logic.
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE: if (w_accept) w_next = HDR;
      HDR: begin
        if (w_adv && (r_hdr_nib == 4'(UDP_HDR_NIBBLES - 1))) begin
          if (r_len != '0) w_next = PAY;
`ifdef UDP_MIN_PAD_EN
          else             w_next = PAD;
`else
          else             w_next = FIN;
`endif
        end
      end
      PAY: begin
`ifdef UDP_MIN_PAD_EN
        if (w_adv && (r_nib_cnt == 13'd1)) w_next = w_pad_need ? PAD : FIN;
`else
        if (w_adv && (r_nib_cnt == 13'd1)) w_next = FIN;
`endif
      end
`ifdef UDP_MIN_PAD_EN
      PAD: if (w_adv && (r_nib_cnt == 13'd1)) w_next = FIN;
`endif
      FIN:     w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // Per-state combinational outputs: accept/reject, byte source, FIFO pop.
  always_comb begin
    w_accept = 1'b0;
    w_reject = 1'b0;
    w_stream = 1'b0;
    w_byte   = 8'h00;
    w_pl_rd  = 1'b0;
    unique case (r_state)
      IDLE: begin
        w_reject = start && (payload_len > LEN_W'(UDP_MAX_PAYLOAD));
        w_accept = start && !w_reject;
      end
      HDR: begin
        w_stream = 1'b1;
        w_byte   = hdr_byte(r_hdr_nib[3:1], w_hdr);
      end
      PAY: begin
        // An empty FIFO sends a zero byte and leaves the FIFO untouched.
        w_stream = 1'b1;
        w_byte   = pl_empty ? 8'h00 : pl_data;
        w_pl_rd  = nib_rq && w_phase_hi && !pl_empty;
      end
`ifdef UDP_MIN_PAD_EN
      PAD: w_stream = 1'b1;
`endif
      default: ;
    endcase
  end

  assign w_adv = w_stream && nib_rq;
  assign pl_rd = w_pl_rd;

  udp_nibble_ser u_ser (
    .mii_tx_clk (mii_tx_clk),
    .rst_n      (rst_n),
    .i_clr      (w_accept),
    .i_adv      (w_adv),
    .i_byte     (w_byte),
    .o_nib_c    (w_nib),
    .o_phase_hi (w_phase_hi)
  );

  // Registered outputs and datapath.
  always_ff @(posedge mii_tx_clk or negedge rst_n) begin
    if (!rst_n) begin
      r_src       <= '0;
      r_dst       <= '0;
      r_len       <= '0;
      r_hdr_nib   <= '0;
      r_nib_cnt   <= '0;
      tx_go_o     <= 1'b0;
      ip_data_len <= '0;
      nib_da      <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      len_err     <= 1'b0;
      underrun    <= 1'b0;
    end else begin
      tx_go_o <= w_accept;
      len_err <= w_reject;
      done    <= (w_next == FIN);
      busy    <= (w_next != IDLE);
      if (w_accept) begin
        r_src       <= src_port;
        r_dst       <= dst_port;
        r_len       <= payload_len;
        r_hdr_nib   <= '0;
        r_nib_cnt   <= {payload_len, 1'b0};
        ip_data_len <= w_ip_len;
        underrun    <= 1'b0;
      end
      // nib_da holds while nib_rq is low; it returns to zero once FIN is left.
      if (w_adv) begin
        nib_da <= w_nib;
        if (r_state == HDR) r_hdr_nib <= r_hdr_nib + 4'd1;
        else                r_nib_cnt <= r_nib_cnt - 13'd1;
      end else if ((r_state == IDLE) || (r_state == FIN)) begin
        nib_da <= '0;
      end
      if (w_adv && (r_state == PAY) && pl_empty) underrun <= 1'b1;
`ifdef UDP_MIN_PAD_EN
      if ((w_next == PAD) && (r_state != PAD)) r_nib_cnt <= w_pad_nibs;
`endif
    end
  end

endmodule
